// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file write path.
//
// Contents:
//   REG_W, DATA_W, NUM_REGS : register-file geometry (5-bit address, 32-bit data, 32 regs)
//   wb_entry_t              : one buffered multi-cycle result {dest, data, live}
//   regOneHot()             : decode a register address into a NUM_REGS-wide one-hot mask
package cpu_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // A buffered result. 'live' drops when a younger pipeline write to the
    // same register makes this result obsolete; the entry still occupies its
    // slot until it reaches the head and is popped without writing.
    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
        logic              live;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] regOneHot(input logic [REG_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for multi-cycle unit results waiting for the register-file
// write port.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : write pushEntry_i at the tail (ignored when full)
//   pushEntry_i     : entry to store
//   pop_i           : retire the head entry (ignored when empty)
//   killEn_i        : mark every live entry whose dest equals killReg_i as dead
//   killReg_i       : register being overwritten by a younger pipeline result
//   head_o          : current head entry (meaningful only when !empty_o)
//   empty_o, full_o : occupancy flags, derived from registered pointers only
//   pendMask_o      : OR of one-hot dest decodes of all live entries, bit 0 forced low
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  wb_entry_t            pushEntry_i,
    input  logic                 pop_i,
    input  logic                 killEn_i,
    input  logic [REG_W-1:0]     killReg_i,
    output wb_entry_t            head_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [NUM_REGS-1:0]  pendMask_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [PTR_W:0]   wrPtr_q;
    logic [PTR_W:0]   rdPtr_q;
    logic [PTR_W-1:0] wrIdx;
    logic [PTR_W-1:0] rdIdx;
    wb_entry_t        mem_q [DEPTH];

    assign wrIdx   = wrPtr_q[PTR_W-1:0];
    assign rdIdx   = rdPtr_q[PTR_W-1:0];
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) && (wrIdx == rdIdx);
    assign head_o  = mem_q[rdIdx];

    // Kill is applied to resident entries before the push is written, so an
    // entry arriving in the same cycle as a matching pipeline write stays live
    // (it is the younger result). Popped slots are cleared so the pending mask
    // only ever reflects occupied, live entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (killEn_i && mem_q[i].live && (mem_q[i].dest == killReg_i)) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (pop_i && !empty_o) begin
                mem_q[rdIdx].live <= 1'b0;
                rdPtr_q           <= rdPtr_q + 1'b1;
            end
            if (push_i && !full_o) begin
                mem_q[wrIdx] <= pushEntry_i;
                wrPtr_q      <= wrPtr_q + 1'b1;
            end
        end
    end

    always_comb begin
        pendMask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].live) begin
                pendMask_o = pendMask_o | regOneHot(mem_q[i].dest);
            end
        end
        pendMask_o[0] = 1'b0;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-side front end of the 32x32 register file. Owns the single write port
// and merges the in-order pipeline write-back (no backpressure, always wins)
// with a buffered multi-cycle result stream.
//
// Ports:
//   Clk, Rst_n                    : clock, asynchronous active-low reset
//   PipeWrite, PipeReg, PipeData  : pipeline write-back request
//   MulValid, MulReg, MulData     : multi-cycle result offer
//   MulReady                      : buffer can accept (not full), from state only
//   RegWrite, WriteReg, WriteData : registered write port to the register file
//   PendingMask                   : registers targeted by live buffered results
//   StallReq                      : ask the pipeline to hold off write-back
module reg_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                PipeWrite,
    input  logic [REG_W-1:0]    PipeReg,
    input  logic [DATA_W-1:0]   PipeData,
    input  logic                MulValid,
    input  logic [REG_W-1:0]    MulReg,
    input  logic [DATA_W-1:0]   MulData,
    output logic                MulReady,
    output logic                RegWrite,
    output logic [REG_W-1:0]    WriteReg,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] PendingMask,
    output logic                StallReq
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic                pipeIssue;
    logic                mulAccept;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoEmpty;
    logic                fifoFull;
    wb_entry_t           pushEntry;
    wb_entry_t           headEntry;
    logic [NUM_REGS-1:0] pendMask;

    logic                regWrite_q,  regWrite_d;
    logic [REG_W-1:0]    writeReg_q,  writeReg_d;
    logic [DATA_W-1:0]   writeData_q, writeData_d;
    logic [CNT_W-1:0]    starveCnt_q, starveCnt_d;
    logic                stallReq_q,  stallReq_d;

    // A pipeline write to r0 is a no-op and must not steal the port from the
    // buffer. A handshake to r0 is accepted but never stored.
    assign MulReady  = !fifoFull;
    assign pipeIssue = PipeWrite && (PipeReg != '0);
    assign mulAccept = MulValid && MulReady;
    assign fifoPush  = mulAccept && (MulReg != '0);
    assign fifoPop   = !pipeIssue && !fifoEmpty;
    assign pushEntry = '{dest: MulReg, data: MulData, live: 1'b1};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .push_i      (fifoPush),
        .pushEntry_i (pushEntry),
        .pop_i       (fifoPop),
        .killEn_i    (pipeIssue),
        .killReg_i   (PipeReg),
        .head_o      (headEntry),
        .empty_o     (fifoEmpty),
        .full_o      (fifoFull),
        .pendMask_o  (pendMask)
    );

    // Issue selection. When nothing is written (idle, or a dead head is
    // discarded) the address and data registers keep their last values.
    // The starve counter only grows while the head waits behind a pipeline
    // write: non-empty and not popping implies the pipeline issued.
    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        if (pipeIssue) begin
            regWrite_d  = 1'b1;
            writeReg_d  = PipeReg;
            writeData_d = PipeData;
        end else if (fifoPop && headEntry.live) begin
            regWrite_d  = 1'b1;
            writeReg_d  = headEntry.dest;
            writeData_d = headEntry.data;
        end

        starveCnt_d = starveCnt_q;
        if (fifoEmpty || fifoPop) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != STARVE_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
        stallReq_d = (starveCnt_d >= STARVE_MAX);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            starveCnt_q <= '0;
            stallReq_q  <= 1'b0;
        end else begin
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            starveCnt_q <= starveCnt_d;
            stallReq_q  <= stallReq_d;
        end
    end

    assign RegWrite    = regWrite_q;
    assign WriteReg    = writeReg_q;
    assign WriteData   = writeData_q;
    assign StallReq    = stallReq_q;
    assign PendingMask = pendMask;

endmodule
